// File: rtl/tl45_fetch.sv
// tl45 instruction fetch: pc, pipelined Wishbone read, skid and decode buffer.
// Optional TL45_FETCH_ERR_EN: bus errors and misaligned redirects trap to ERR.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] redir_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        skid_valid;
  logic [31:0] word_pc;
  logic [31:0] word_inst;
  logic        busy;
  logic        done;
  logic        fault;
  logic        redir_bad;

  always_comb begin
    pc_inc   = pc + 32'd4;
    redir_pc = i_redirect_pc & ~32'd3;
    busy     = (state == S_WAIT) ||
               ((state == S_REQ) && !i_wb_stall);
`ifdef TL45_FETCH_ERR_EN
    done      = busy && i_wb_ack && !i_wb_err;
    fault     = busy && i_wb_err;
    redir_bad = |i_redirect_pc[1:0];
    word_pc   = pc;
    word_inst = i_wb_data;
`else
    // a bus error completes the slot as a bubble
    done      = busy && (i_wb_ack || i_wb_err);
    fault     = 1'b0;
    redir_bad = 1'b0;
    word_pc   = i_wb_err ? 32'd0 : pc;
    word_inst = i_wb_err ? 32'd0 : i_wb_data;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      skid_pc     <= '0;
      skid_inst   <= '0;
      skid_valid  <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_addr   <= '0;
      o_buf_pc    <= '0;
      o_buf_inst  <= '0;
      o_fetch_err <= 1'b0;
    end else if (i_redirect && state != S_ERR) begin
      pc         <= redir_pc;
      o_buf_pc   <= '0;
      o_buf_inst <= '0;
      skid_valid <= 1'b0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      state      <= redir_bad ? S_ERR : S_IDLE;
      if (redir_bad)
        o_fetch_err <= 1'b1;
    end else begin
      if (state == S_ERR) begin
        o_buf_pc   <= '0;
        o_buf_inst <= '0;
      end else if (!i_pipe_stall) begin
        if (state == S_HOLD && skid_valid) begin
          o_buf_pc   <= skid_pc;
          o_buf_inst <= skid_inst;
        end else if (done) begin
          o_buf_pc   <= word_pc;
          o_buf_inst <= word_inst;
        end else begin
          o_buf_pc   <= '0;
          o_buf_inst <= '0;
        end
      end
      unique case (state)
        S_IDLE: begin
          o_wb_cyc  <= 1'b1;
          o_wb_stb  <= 1'b1;
          o_wb_addr <= pc[31:2];
          state     <= S_REQ;
        end
        S_REQ, S_WAIT: begin
          if (fault) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_fetch_err <= 1'b1;
            state       <= S_ERR;
          end else if (done) begin
            pc <= pc_inc;
            if (!i_pipe_stall) begin
              o_wb_stb  <= 1'b1;
              o_wb_addr <= pc_inc[31:2];
              state     <= S_REQ;
            end else begin
              skid_pc    <= word_pc;
              skid_inst  <= word_inst;
              skid_valid <= 1'b1;
              o_wb_cyc   <= 1'b0;
              o_wb_stb   <= 1'b0;
              state      <= S_HOLD;
            end
          end else if (state == S_REQ && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (!i_pipe_stall) begin
            skid_valid <= 1'b0;
            o_wb_cyc   <= 1'b1;
            o_wb_stb   <= 1'b1;
            o_wb_addr  <= pc[31:2];
            state      <= S_REQ;
          end
        end
        S_ERR: begin
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
